// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl_if : stall/flush requests and multi-cycle handshake bundle  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_id_i;
  logic             ex_mc_req_i;
  logic             mc_done_i;
  logic             flush_req_i;
  logic [5:0]       stall_o;
  logic             flush_o;
  logic             mc_start_o;
  logic             mc_abort_o;
  logic             mc_busy_o;
  logic             mc_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport slave (
    input  stallreq_id_i, ex_mc_req_i, mc_done_i, flush_req_i,
    output stall_o, flush_o, mc_start_o, mc_abort_o, mc_busy_o,
           mc_timeout_o, stall_cnt_o
  );

  modport master (
    output stallreq_id_i, ex_mc_req_i, mc_done_i, flush_req_i,
    input  stall_o, flush_o, mc_start_o, mc_abort_o, mc_busy_o,
           mc_timeout_o, stall_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl : pipeline stall/flush control, multi-cycle unit sequencer  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int MC_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MC_RUN = 2'd1;
  localparam logic [1:0] S_FAULT  = 2'd2;
  localparam logic [7:0] MC_LIMIT = 8'(MC_TIMEOUT - 1);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  logic [1:0]       state_q, state_d;
  logic [7:0]       mc_cnt_q, mc_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [5:0]       stall;
  logic             flush;
  logic             mc_start;
  logic             mc_abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mc_cnt_q    <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mc_cnt_d  = mc_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.flush_req_i && bus.ex_mc_req_i) begin
          state_d  = S_MC_RUN;
          mc_cnt_d = 8'd0;
        end
      end
      S_MC_RUN: begin
        if (bus.flush_req_i || bus.mc_done_i) begin
          state_d = S_IDLE;
        end else if (mc_cnt_q == MC_LIMIT) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end else begin
          mc_cnt_d = mc_cnt_q + 8'd1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is held so an in-flight request
  // cannot leak a start or stall through the asynchronous reset window.
  always_comb begin
    stall    = STALL_NONE;
    flush    = 1'b0;
    mc_start = 1'b0;
    mc_abort = 1'b0;
    if (rst) begin
      case (state_q)
        S_IDLE: begin
          if (bus.flush_req_i) begin
            flush = 1'b1;
          end else if (bus.ex_mc_req_i) begin
            mc_start = 1'b1;
            stall    = STALL_EX;
          end else if (bus.stallreq_id_i) begin
            stall = STALL_ID;
          end
        end
        S_MC_RUN: begin
          if (bus.flush_req_i) begin
            flush    = 1'b1;
            mc_abort = 1'b1;
          end else if (bus.mc_done_i) begin
            stall = STALL_NONE;
          end else if (mc_cnt_q == MC_LIMIT) begin
            mc_abort = 1'b1;
            stall    = STALL_ALL;
          end else begin
            stall = STALL_EX;
          end
        end
        S_FAULT: stall = STALL_ALL;
        default: stall = STALL_NONE;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall != STALL_NONE) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_o      = stall;
  assign bus.flush_o      = flush;
  assign bus.mc_start_o   = mc_start;
  assign bus.mc_abort_o   = mc_abort;
  assign bus.mc_busy_o    = (state_q == S_MC_RUN);
  assign bus.mc_timeout_o = timeout_q;
  assign bus.stall_cnt_o  = stall_cnt_q;

endmodule
`default_nettype wire
